// File: rtl/lenet_mac_pkg.sv
// Shared widths, sideband payload and fixed-point helpers for the LeNet MAC datapath.
package lenet_mac_pkg;

    localparam int unsigned ACC_W_DEF  = 40;
    localparam int unsigned DOUT_W_DEF = 16;
    localparam int unsigned CALC_W     = 64;

    typedef logic signed [CALC_W-1:0] calc_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } mac_side_t;

    function automatic calc_t sat_max(input int unsigned w);
        return (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    endfunction

    function automatic calc_t sat_min(input int unsigned w);
        return -(calc_t'(1) <<< (w - 1));
    endfunction

    // Round half up, then arithmetic shift; caller keeps the operand within CALC_W-1 bits.
    function automatic calc_t round_shift(input calc_t a, input int unsigned sh);
        calc_t half;
        half = (sh > 0) ? (calc_t'(1) <<< (sh - 1)) : '0;
        return (a + half) >>> sh;
    endfunction

endpackage

// File: rtl/lenet_mul_pipe.sv
// Signed multiplier followed by a NUM_STAGE register chain carrying valid/first/last and bias.
module lenet_mul_pipe
    import lenet_mac_pkg::*;
#(
    parameter int unsigned DIN0_WIDTH = 16,
    parameter int unsigned DIN1_WIDTH = 16,
    parameter int unsigned NUM_STAGE  = 2,
    parameter int unsigned ACC_WIDTH  = ACC_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ce,
    input  logic                        in_valid,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic [DIN0_WIDTH-1:0]       din0,
    input  logic [DIN1_WIDTH-1:0]       din1,
    input  logic [ACC_WIDTH-1:0]        bias,
    output logic                        p_valid,
    output logic                        p_first,
    output logic                        p_last,
    output logic signed [ACC_WIDTH-1:0] p_prod,
    output logic signed [ACC_WIDTH-1:0] p_bias
);

    localparam int unsigned PW = DIN0_WIDTH + DIN1_WIDTH;

    logic signed [PW-1:0]        prod_c;
    mac_side_t                   side_q [NUM_STAGE];
    logic signed [PW-1:0]        prod_q [NUM_STAGE];
    logic signed [ACC_WIDTH-1:0] bias_q [NUM_STAGE];

    assign prod_c = PW'($signed(din0)) * PW'($signed(din1));

    // Sideband flags are reset; first/last only count when the term is valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_STAGE; i++) begin
                side_q[i] <= '0;
            end
        end else if (ce) begin
            side_q[0] <= '{valid: in_valid, first: in_valid & in_first, last: in_valid & in_last};
            for (int unsigned i = 1; i < NUM_STAGE; i++) begin
                side_q[i] <= side_q[i-1];
            end
        end
    end

    // Payload registers need no reset: they are only consumed under a valid flag.
    always_ff @(posedge clk) begin
        if (ce) begin
            prod_q[0] <= prod_c;
            bias_q[0] <= $signed(bias);
            for (int unsigned i = 1; i < NUM_STAGE; i++) begin
                prod_q[i] <= prod_q[i-1];
                bias_q[i] <= bias_q[i-1];
            end
        end
    end

    assign p_valid = side_q[NUM_STAGE-1].valid;
    assign p_first = side_q[NUM_STAGE-1].first;
    assign p_last  = side_q[NUM_STAGE-1].last;
    assign p_prod  = ACC_WIDTH'(prod_q[NUM_STAGE-1]);
    assign p_bias  = bias_q[NUM_STAGE-1];

endmodule

// File: rtl/lenet_mac_pipe.sv
// Pipelined signed MAC: multiplier chain, burst accumulator with bias preload,
// then a round/shift stage and a saturating output stage.
module lenet_mac_pipe
    import lenet_mac_pkg::*;
#(
    parameter int unsigned DIN0_WIDTH = 16,
    parameter int unsigned DIN1_WIDTH = 16,
    parameter int unsigned NUM_STAGE  = 2,
    parameter int unsigned ACC_WIDTH  = ACC_W_DEF,
    parameter int unsigned DOUT_WIDTH = DOUT_W_DEF,
    parameter int unsigned FRAC_SHIFT = 8,
    parameter bit          SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic [ACC_WIDTH-1:0]  bias,
    output logic                  out_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  acc_ovf,
    output logic                  seq_err
);

    localparam int unsigned RW = ACC_WIDTH + 1;

    generate
        if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_bad_stage
            $error("lenet_mac_pipe: NUM_STAGE must be 1..4");
        end
        if (ACC_WIDTH < DIN0_WIDTH + DIN1_WIDTH || RW >= CALC_W) begin : g_bad_acc
            $error("lenet_mac_pipe: ACC_WIDTH out of range");
        end
        if (FRAC_SHIFT >= ACC_WIDTH || DOUT_WIDTH > RW) begin : g_bad_out
            $error("lenet_mac_pipe: FRAC_SHIFT/DOUT_WIDTH out of range");
        end
    endgenerate

    logic                        p_valid;
    logic                        p_first;
    logic                        p_last;
    logic signed [ACC_WIDTH-1:0] p_prod;
    logic signed [ACC_WIDTH-1:0] p_bias;

    lenet_mul_pipe #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .NUM_STAGE  (NUM_STAGE),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mul (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .in_valid (in_valid),
        .in_first (in_first),
        .in_last  (in_last),
        .din0     (din0),
        .din1     (din1),
        .bias     (bias),
        .p_valid  (p_valid),
        .p_first  (p_first),
        .p_last   (p_last),
        .p_prod   (p_prod),
        .p_bias   (p_bias)
    );

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] base_c;
    logic signed [ACC_WIDTH-1:0] sum_c;
    logic                        add_ovf_c;
    logic                        restart_c;
    logic                        ovf_q;
    logic                        open_q;
    logic                        acc_last_q;
    logic signed [RW-1:0]        r_q;
    logic                        r_valid_q;
    logic                        r_ovf_q;
    calc_t                       r_ext_c;
    logic                        clamp_hi_c;
    logic                        clamp_lo_c;
    logic [DOUT_WIDTH-1:0]       res_c;

    // An orphan term (no open burst) starts from zero, so it can never overflow on its own.
    always_comb begin
        restart_c = p_first || !open_q;
        base_c    = open_q ? acc_q : '0;
        if (p_first) begin
            base_c = p_bias;
        end
        sum_c     = base_c + p_prod;
        add_ovf_c = (base_c[ACC_WIDTH-1] == p_prod[ACC_WIDTH-1]) &&
                    (sum_c[ACC_WIDTH-1] != base_c[ACC_WIDTH-1]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            open_q     <= 1'b0;
            acc_last_q <= 1'b0;
            seq_err    <= 1'b0;
        end else if (ce) begin
            acc_last_q <= p_valid && p_last;
            seq_err    <= p_valid && !p_first && !open_q;
            if (p_valid) begin
                acc_q  <= sum_c;
                ovf_q  <= restart_c ? add_ovf_c : (ovf_q | add_ovf_c);
                open_q <= !p_last;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q       <= '0;
            r_valid_q <= 1'b0;
            r_ovf_q   <= 1'b0;
        end else if (ce) begin
            r_valid_q <= acc_last_q;
            if (acc_last_q) begin
                r_q     <= RW'(round_shift(calc_t'(acc_q), FRAC_SHIFT));
                r_ovf_q <= ovf_q;
            end
        end
    end

    always_comb begin
        r_ext_c    = calc_t'(r_q);
        clamp_hi_c = SATURATE && (r_ext_c > sat_max(DOUT_WIDTH));
        clamp_lo_c = SATURATE && (r_ext_c < sat_min(DOUT_WIDTH));
        res_c      = r_q[DOUT_WIDTH-1:0];
        if (clamp_hi_c) begin
            res_c = DOUT_WIDTH'(sat_max(DOUT_WIDTH));
        end else if (clamp_lo_c) begin
            res_c = DOUT_WIDTH'(sat_min(DOUT_WIDTH));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            acc_ovf   <= 1'b0;
        end else if (ce) begin
            out_valid <= r_valid_q;
            if (r_valid_q) begin
                dout    <= res_c;
                acc_ovf <= r_ovf_q | clamp_hi_c | clamp_lo_c;
            end
        end
    end

endmodule
